// File: rtl/cipher_pkg.sv
// cipher_pkg: shared FSM states, ASCII bounds and key reduction for the Caesar cipher path
package cipher_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_UZ = 8'h5A;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LZ = 8'h7A;
  localparam logic [5:0] ALPHA_LEN = 6'd26;
  localparam logic [4:0] ROT13_KEY = 5'd13;
  function automatic logic [4:0] reduce_key(input logic rot13, input logic [4:0] shift_key);
    return rot13 ? ROT13_KEY : (shift_key >= ALPHA_LEN[4:0] ? shift_key - ALPHA_LEN[4:0] : shift_key);
  endfunction
endpackage

// File: rtl/caesar_shift_char.sv
// caesar_shift_char: rotates ASCII letters by key_eff (0..25) within their case, other bytes pass through
module caesar_shift_char
  import cipher_pkg::*;
(
  input  logic [7:0] char_in,
  input  logic [4:0] key_eff,
  output logic [7:0] char_out
);
  logic       is_up, is_lo;
  logic [7:0] base;
  logic [5:0] off, wrapped;
  always_comb begin
    is_up = char_in >= ASCII_UA && char_in <= ASCII_UZ;
    is_lo = char_in >= ASCII_LA && char_in <= ASCII_LZ;
    base = is_up ? ASCII_UA : ASCII_LA;
    off = 6'(char_in - base) + {1'b0, key_eff};
    wrapped = off >= ALPHA_LEN ? off - ALPHA_LEN : off;
    char_out = (is_up || is_lo) ? base + {2'b00, wrapped} : char_in;
  end
endmodule

// File: rtl/caesar_stream_encryptor.sv
// caesar_stream_encryptor: streams PT memory through a Caesar shift into CT memory, done/okay handoff
module caesar_stream_encryptor
  import cipher_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              okay,
  input  logic              rot13,
  input  logic [4:0]        shift_key,
  input  logic [ADDR_W-1:0] msg_length_byte,
  output logic [ADDR_W-1:0] pt_addr,
  output logic              pt_re,
  input  logic [7:0]        pt_rdata,
  output logic [ADDR_W-1:0] ct_addr,
  output logic [7:0]        ct_wdata,
  output logic              ct_we,
  output logic              busy,
  output logic              done
);
  state_t            state, state_nx;
  logic [ADDR_W-1:0] idx, len, rd_addr;
  logic [4:0]        key;
  logic              rd_v, go;
  logic [7:0]        enc;

  caesar_shift_char u_shift (
    .char_in (pt_rdata),
    .key_eff (key),
    .char_out(enc)
  );

  // byte 0 is read in the start cycle itself so that done lands exactly len+2 cycles later
  always_comb begin
    go = state == IDLE && start;
    pt_re = reset && (state == RUN || (go && msg_length_byte != '0));
    pt_addr = state == RUN ? idx : '0;
    busy = state == RUN || state == DRAIN;
    done = state == DONE;
    state_nx = state == IDLE  ? (!start ? IDLE :
                                 msg_length_byte == '0 ? DONE :
                                 msg_length_byte == ADDR_W'(1) ? DRAIN : RUN) :
               state == RUN   ? (idx == len - ADDR_W'(1) ? DRAIN : RUN) :
               state == DRAIN ? (rd_v ? DRAIN : DONE) :
                                (okay ? IDLE : DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx <= '0;
      len <= '0;
      key <= '0;
      rd_v <= 1'b0;
      rd_addr <= '0;
      ct_we <= 1'b0;
      ct_addr <= '0;
      ct_wdata <= '0;
    end else begin
      state <= state_nx;
      if (go) begin
        len <= msg_length_byte;
        key <= reduce_key(rot13, shift_key);
        idx <= ADDR_W'(1);
      end else if (state == RUN) begin
        idx <= idx + ADDR_W'(1);
      end
      rd_v <= pt_re;
      rd_addr <= pt_addr;
      ct_we <= rd_v;
      if (rd_v) begin
        ct_addr <= rd_addr;
        ct_wdata <= enc;
      end
    end
  end
endmodule

// File: tb/tb_caesar_stream_encryptor.sv
// tb_caesar_stream_encryptor: directed and random streams checked against a modular-arithmetic Caesar model
module tb_caesar_stream_encryptor;
  logic       clk = 1'b0;
  logic       reset, start, okay, rot13;
  logic [4:0] shift_key;
  logic [7:0] msg_length_byte, pt_addr, pt_rdata, ct_addr, ct_wdata;
  logic       pt_re, ct_we, busy, done;
  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  int         cyc = 0, we_cnt = 0, first_we = -1;
  int         n_vec = 0, n_err = 0;

  caesar_stream_encryptor #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .okay(okay), .rot13(rot13),
    .shift_key(shift_key), .msg_length_byte(msg_length_byte),
    .pt_addr(pt_addr), .pt_re(pt_re), .pt_rdata(pt_rdata),
    .ct_addr(ct_addr), .ct_wdata(ct_wdata), .ct_we(ct_we),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial pt_rdata = 8'h00;
  always @(posedge clk) if (pt_re) pt_rdata <= pt_mem[pt_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // writes must arrive in address order, one per cycle
  always @(negedge clk) if (ct_we) begin
    chk("ct_addr_order", 32'(ct_addr), we_cnt);
    if (we_cnt == 0) first_we = cyc;
    ct_mem[ct_addr] = ct_wdata;
    we_cnt++;
  end

  function automatic logic [7:0] ref_enc(input logic [7:0] c, input int k);
    int v = int'(c);
    if (v >= 65 && v <= 90) return 8'(65 + (v - 65 + k) % 26);
    if (v >= 97 && v <= 122) return 8'(97 + (v - 97 + k) % 26);
    return c;
  endfunction

  task automatic load(input string p);
    for (int i = 0; i < p.len(); i++) pt_mem[i] = p[i];
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++)
      case ($urandom_range(0, 3))
        0: pt_mem[i] = 8'($urandom);
        1: pt_mem[i] = 8'($urandom_range(65, 90));
        2: pt_mem[i] = 8'($urandom_range(97, 122));
        default: pt_mem[i] = 8'($urandom_range(0, 1) ? $urandom_range(64, 91) : $urandom_range(96, 123));
      endcase
  endtask

  task automatic cmp_str(input string tag, input string e);
    for (int i = 0; i < e.len(); i++) chk(tag, ct_mem[i], e[i]);
  endtask

  task automatic run(input int len, input logic r13, input logic [4:0] k, input bit poke);
    int s, t, ke;
    ke = r13 ? 13 : int'(k) % 26;
    foreach (ct_mem[i]) ct_mem[i] = 'x;
    we_cnt = 0;
    first_we = -1;
    rot13 = r13;
    shift_key = k;
    msg_length_byte = 8'(len);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    rot13 = 1'($urandom);
    shift_key = 5'($urandom);
    msg_length_byte = 8'($urandom);
    t = 0;
    while (!done && t < 400) begin
      @(negedge clk);
      t++;
      start = poke && t == 3;
    end
    start = 1'b0;
    chk("done_latency", cyc - s, len == 0 ? 1 : len + 2);
    chk("ct_we_count", we_cnt, len);
    if (len > 0) chk("first_ct_we", first_we - s, 2);
    for (int i = 0; i < len; i++) chk("ct_byte", ct_mem[i], ref_enc(pt_mem[i], ke));
    chk("busy_in_done", busy, 0);
  endtask

  task automatic ack();
    okay = 1'b1;
    @(negedge clk);
    okay = 1'b0;
    chk("done_after_okay", done, 0);
    chk("busy_after_okay", busy, 0);
  endtask

  localparam string FOX_PT = "The quick brown fox jumps over the lazy dog";
  localparam string FOX_CT = "Wkh txlfn eurzq ira mxpsv ryhu wkh odcb grj";

  initial begin
    int t, n;
    reset = 1'b0; start = 1'b0; okay = 1'b0; rot13 = 1'b0; shift_key = '0; msg_length_byte = '0;
    repeat (2) @(negedge clk);
    chk("rst_pt_re", pt_re, 0);
    chk("rst_ct_we", ct_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    @(negedge clk);

    load(FOX_PT);
    run(43, 1'b0, 5'd3, 1'b0);
    cmp_str("fox_k3", FOX_CT);
    chk("fox_ct0", ct_mem[0], 8'h57);
    ack();

    load("xyz XYZ!");
    run(8, 1'b0, 5'd3, 1'b0);
    cmp_str("wrap_pass", "abc ABC!");
    ack();

    load(FOX_PT);
    run(43, 1'b0, 5'd29, 1'b0);
    cmp_str("fox_k29", FOX_CT);
    ack();

    load("Matou Sakura is the best girl");
    run(29, 1'b1, 5'd7, 1'b0);
    cmp_str("rot13", "Zngbh Fnxhen vf gur orfg tvey");
    ack();

    run(0, 1'b0, 5'd5, 1'b0);
    ack();

    fill(20);
    run(20, 1'b0, 5'($urandom), 1'b1);
    repeat (100) @(negedge clk);
    chk("done_hold", done, 1);
    start = 1'b1;
    msg_length_byte = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_in_done_done", done, 1);
    chk("start_in_done_busy", busy, 0);
    chk("start_in_done_we", we_cnt, 20);
    ack();
    okay = 1'b1;
    repeat (3) @(negedge clk);
    okay = 1'b0;
    chk("okay_idle_busy", busy, 0);
    chk("okay_idle_done", done, 0);
    chk("okay_idle_pt_re", pt_re, 0);

    fill(40);
    we_cnt = 0;
    rot13 = 1'b0; shift_key = 5'd4; msg_length_byte = 8'd40; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (pt_addr != 8'd10 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("mid_run_idx10", pt_addr, 10);
    reset = 1'b0;
    #1;
    chk("async_pt_re", pt_re, 0);
    chk("async_pt_addr", pt_addr, 0);
    chk("async_ct_we", ct_we, 0);
    chk("async_ct_addr", ct_addr, 0);
    chk("async_ct_wdata", ct_wdata, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    fill(30);
    run(30, 1'b0, 5'd11, 1'b0);
    ack();

    repeat (6) begin
      n = $urandom_range(1, 60);
      fill(n);
      run(n, 1'($urandom), 5'($urandom), 1'b0);
      ack();
    end

    fill(255);
    run(255, 1'b0, 5'($urandom), 1'b0);
    ack();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
